// File: rtl/udp_filter_port_sched.sv
// Purpose: frame-granular round-robin scheduler that shares one udp_filter and its output FIFO between PORT_NR AXI-Stream ports.
// Latency: ARB->ARM->STREAM costs 2 cycles per frame; granted beats reach the filter in the same cycle; DRAIN needs at least 2 idle cycles.
// Backpressure: there is none toward the filter. Ungranted ports see tready=0. A stalled frame is timed out, flushed and the filter is reset.
// Ports:
//   clk_i, a_rst_n_i      : clock and asynchronous active-low reset
//   en_i, timeout_i       : grant enable, and the stall limit in cycles (0 disables it)
//   ipv4_addr_i, s_axis_* : per-port address slices and ingress streams
//   flt_*                 : filter control, data mux and filter status
//   grant_o, busy_o       : one-hot grant, and a flag that is high outside ARB
//   abort_cnt_o           : saturating count of aborted frames
//   frame_cnt_o           : wrapping count of completed frames
module udp_filter_port_sched #(
   parameter int PORT_NR         = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int IPV4_ADDR_WIDTH = 32,
   parameter int TIMEOUT_WIDTH   = 16
) (
   input  logic                               clk_i,
   input  logic                               a_rst_n_i,
   input  logic                               en_i,
   input  logic [TIMEOUT_WIDTH-1:0]           timeout_i,
   input  logic [PORT_NR*IPV4_ADDR_WIDTH-1:0] ipv4_addr_i,
   input  logic [PORT_NR*DATA_WIDTH-1:0]      s_axis_tdata_i,
   input  logic [PORT_NR-1:0]                 s_axis_tvalid_i,
   input  logic [PORT_NR-1:0]                 s_axis_tlast_i,
   output logic [PORT_NR-1:0]                 s_axis_tready_o,
   output logic                               flt_en_o,
   output logic                               flt_s_rst_n_o,
   output logic [IPV4_ADDR_WIDTH-1:0]         flt_ipv4_addr_o,
   output logic [DATA_WIDTH-1:0]              flt_data_o,
   output logic                               flt_valid_o,
   output logic                               flt_last_o,
   input  logic                               flt_frame_valid_i,
   input  logic                               flt_fifo_empty_i,
   output logic [PORT_NR-1:0]                 grant_o,
   output logic                               busy_o,
   output logic [15:0]                        abort_cnt_o,
   output logic [15:0]                        frame_cnt_o
);
   localparam int IW = (PORT_NR > 1) ? $clog2(PORT_NR) : 1;

   typedef enum logic [2:0] {ARB, ARM, STREAM, DRAIN, ABORT} state_t;

   state_t               state, state_nxt;
   logic [IW-1:0]        rr_ptr, gidx, sel_idx, gidx_inc;
   logic [PORT_NR-1:0]   sel_oh;
   logic                 sel_found;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt, tmo_inc;
   logic                 tmo_hit;
   logic                 ok_cnt;      // previous DRAIN cycle was already idle
   logic                 ab_second;   // second ABORT cycle
   logic                 beat, drain_good, drain_exit;

   // Round-robin search: first requester at or above rr_ptr, with wrap.
   always_comb begin
      int idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_oh    = '0;
      for (int i = 0; i < PORT_NR; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= PORT_NR) idx = idx - PORT_NR;
         if (!sel_found && s_axis_tvalid_i[idx]) begin
            sel_found   = 1'b1;
            sel_idx     = IW'(idx);
            sel_oh      = '0;
            sel_oh[idx] = 1'b1;
         end
      end
   end

   assign gidx_inc   = (gidx == IW'(PORT_NR-1)) ? '0 : gidx + 1'b1;
   assign beat       = (state == STREAM) && s_axis_tvalid_i[gidx];
   assign drain_good = !flt_frame_valid_i && flt_fifo_empty_i;
   assign drain_exit = (state == DRAIN) && drain_good && ok_cnt;
   // The counter saturates so a disabled timeout never wraps into a false hit.
   assign tmo_inc    = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
   // Compare against the live limit, so a lowered timeout takes effect at once.
   assign tmo_hit    = (timeout_i != '0) && (tmo_inc >= timeout_i);

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (en_i && sel_found) state_nxt = ARM;
         ARM:     state_nxt = STREAM;
         STREAM:  begin
            if (beat) begin
               if (s_axis_tlast_i[gidx]) state_nxt = DRAIN;
            end else if (tmo_hit) begin
               state_nxt = ABORT;
            end
         end
         DRAIN:   begin
            if (drain_exit)   state_nxt = ARB;
            else if (tmo_hit) state_nxt = ABORT;
         end
         ABORT:   if (ab_second) state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   assign busy_o          = (state != ARB);
   assign flt_en_o        = (state == ARM) || (state == STREAM) || (state == DRAIN);
   // ABORT keeps tready high so the rest of the stalled frame is discarded.
   assign s_axis_tready_o = ((state == STREAM) || (state == ABORT)) ? grant_o : '0;
   assign flt_valid_o     = beat;
   assign flt_last_o      = beat && s_axis_tlast_i[gidx];
   assign flt_data_o      = (state == STREAM) ?
                            s_axis_tdata_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

   always_ff @(posedge clk_i or negedge a_rst_n_i) begin
      if (!a_rst_n_i) begin
         state           <= ARB;
         flt_s_rst_n_o   <= 1'b0;
         rr_ptr          <= '0;
         gidx            <= '0;
         grant_o         <= '0;
         flt_ipv4_addr_o <= '0;
         tmo_cnt         <= '0;
         ok_cnt          <= 1'b0;
         ab_second       <= 1'b0;
         abort_cnt_o     <= '0;
         frame_cnt_o     <= '0;
      end else begin
         state         <= state_nxt;
         // Driven from the next state, so the filter reset lines up with the ABORT cycles.
         flt_s_rst_n_o <= (state_nxt != ABORT);
         if (state != ABORT && state_nxt == ABORT && abort_cnt_o != 16'hFFFF)
            abort_cnt_o <= abort_cnt_o + 16'd1;
         case (state)
            ARB: begin
               if (state_nxt == ARM) begin
                  gidx            <= sel_idx;
                  grant_o         <= sel_oh;
                  flt_ipv4_addr_o <= ipv4_addr_i[int'(sel_idx)*IPV4_ADDR_WIDTH +: IPV4_ADDR_WIDTH];
               end
            end
            ARM: tmo_cnt <= '0;
            STREAM: begin
               ok_cnt    <= 1'b0;
               ab_second <= 1'b0;
               tmo_cnt   <= beat ? '0 : tmo_inc;
            end
            DRAIN: begin
               ab_second <= 1'b0;
               ok_cnt    <= drain_good;
               tmo_cnt   <= tmo_inc;
               if (drain_exit) begin
                  frame_cnt_o <= frame_cnt_o + 16'd1;
                  rr_ptr      <= gidx_inc;
                  grant_o     <= '0;
               end
            end
            ABORT: begin
               ab_second <= !ab_second;
               if (ab_second) begin
                  rr_ptr  <= gidx_inc;
                  grant_o <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/udp_filter_port_sched.md
Name: udp_filter_port_sched

Overview:
- Frame-granular round-robin scheduler that shares one udp_filter instance (and its output FIFO) between PORT_NR AXI-Stream ingress ports.
- Grants one port at a time and drives the filter's per-port destination IPv4 address.
- Sequences the filter's enable and synchronous reset so each frame starts from the filter's IDLE state.
- Holds the grant until the filter has finished draining its FIFO, and recovers from stalled frames by timeout and filter reset.

Parameters:
PORT_NR, 4, number of ingress ports (2..8)
DATA_WIDTH, 64, stream data width; fixed to the filter width
IPV4_ADDR_WIDTH, 32, per-port accepted destination address width
TIMEOUT_WIDTH, 16, width of the stall timeout counter

Ports:
clk_i  in  1  clock
a_rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  scheduler enable; when low, no new grants are issued
timeout_i  in  TIMEOUT_WIDTH  stall limit in cycles; 0 disables the timeout
ipv4_addr_i  in  PORT_NR*IPV4_ADDR_WIDTH  per-port destination address; port k uses slice k
s_axis_tdata_i  in  PORT_NR*DATA_WIDTH  per-port data
s_axis_tvalid_i  in  PORT_NR  per-port valid
s_axis_tlast_i  in  PORT_NR  per-port last
s_axis_tready_o  out  PORT_NR  per-port ready
flt_en_o  out  1  to filter en_i
flt_s_rst_n_o  out  1  to filter s_rst_n_i
flt_ipv4_addr_o  out  IPV4_ADDR_WIDTH  to filter ipv4_addr_i
flt_data_o  out  DATA_WIDTH  to filter frame_data_i
flt_valid_o  out  1  to filter frame_data_valid_i
flt_last_o  out  1  to filter frame_last_i
flt_frame_valid_i  in  1  from filter frame_valid_o
flt_fifo_empty_i  in  1  filter FIFO empty flag
grant_o  out  PORT_NR  one-hot current grant; 0 when idle
busy_o  out  1  high in every state except ARB
abort_cnt_o  out  16  saturating count of aborted frames
frame_cnt_o  out  16  wrapping count of completed (non-aborted) frames

Behaviour:
- Reset (async assert, sync release) values:
  - state=ARB, grant_o=0, rr pointer=0, busy_o=0.
  - flt_en_o=0, flt_s_rst_n_o=0, flt_valid_o=0, flt_last_o=0, flt_data_o=0.
  - flt_ipv4_addr_o=0, s_axis_tready_o=0, both counters=0.
- Filter interface:
  - flt_s_rst_n_o is registered: 0 in reset and in ABORT, 1 otherwise.
  - flt_data_o, flt_valid_o and flt_last_o are combinational muxes of the granted port, gated by the STREAM state.
  - flt_ipv4_addr_o is registered at grant and held until the next grant.
- FSM:
  - ARB:
    - If en_i=1 and any tvalid=1, grant the first requesting port searching from rr pointer upward with wrap.
    - Register grant_o and the address; go to ARM.
    - tready=0 on all ports.
  - ARM (exactly 1 cycle):
    - flt_en_o=1, no data presented, so the filter leaves IDLE and latches the address.
    - Go to STREAM.
  - STREAM:
    - flt_en_o=1; tready[g]=1; all other tready=0.
    - Each beat with tvalid[g]=1 is forwarded in the same cycle (zero latency, no backpressure).
    - On a beat with tvalid[g]=1 and tlast[g]=1: go to DRAIN.
  - DRAIN:
    - flt_en_o=1, tready=0.
    - Wait until flt_frame_valid_i=0 and flt_fifo_empty_i=1 for 2 consecutive cycles; minimum dwell is 2 cycles.
    - Then: frame_cnt_o+1, rr pointer=g+1 mod PORT_NR, grant_o=0, go to ARB.
  - ABORT (2 cycles):
    - flt_en_o=0, flt_s_rst_n_o=0, tready[g]=1 so the stalled remainder of the frame is flushed (discarded).
    - abort_cnt_o+1, saturating at 0xFFFF.
    - rr pointer=g+1, go to ARB.
    - Any further beats of that frame arriving later re-arbitrate as a new frame; the filter rejects them by header.
- Timeout:
  - The counter resets on entry to STREAM/DRAIN and on every accepted beat in STREAM.
  - It counts cycles with no beat (STREAM) or with the exit condition unmet (DRAIN).
  - Reaching timeout_i (when not 0) sends the FSM to ABORT.
- Boundary conditions:
  - en_i falling mid-frame: the current frame completes normally; no new grant until en_i=1.
  - en_i going low does not affect flt_en_o inside ARM/STREAM/DRAIN.
  - Single-beat frame (tlast on first beat): STREAM lasts 1 cycle; legal.
  - Only one port requesting: it is re-granted back-to-back; ARB→ARM→STREAM overhead is 2 cycles.
  - timeout_i changing mid-frame: the new value is compared immediately.
  - Asynchronous reset mid-frame: everything returns to reset values immediately; the filter is held in reset.

Test Plan:
- Single port 0, 4-beat frame, addr 0xC0A80001: ARB→ARM(1 cycle, flt_en_o=1, no valid)→4 forwarded beats with flt_last_o on beat 4; after the FIFO empties for 2 cycles, frame_cnt_o=1 and grant_o=0.
- Ports 0, 1 and 3 requesting continuously: grant order 0001, 0010, 1000, 0001; flt_ipv4_addr_o equals the slice of the granted port during ARM.
- Port 2 stalls after 2 beats with timeout_i=16: ABORT entered 16 cycles after the last beat; flt_s_rst_n_o=0 for 2 cycles; abort_cnt_o=1; next grant goes to port 3.
- DRAIN with flt_fifo_empty_i held 0 and timeout_i=0: scheduler stays in DRAIN indefinitely; once empty is released, it exits after 2 cycles.
- Assert a_rst_n_i=0 mid-STREAM: all outputs at reset values within the same cycle; after release, the rr pointer restarts at port 0.
- en_i=0 with all ports requesting: grant_o stays 0 and s_axis_tready_o=0; after en_i rises, port 0 is granted.
